// File: rtl/regfile_wr_arb_if.sv
// Bundles the writeback-source request side and the register-file write port of regfile_wr_arb.
// The slave modport is the arbiter's view; the master modport is the requesters' view.
interface regfile_wr_arb_if #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
);
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic               stall;
    logic [NREQ-1:0]    gnt;
    logic               we3;
    logic [AW-1:0]      a3;
    logic [DW-1:0]      wd3;
    logic               busy;

    modport master (
        output req, req_addr, req_data, stall,
        input  gnt, we3, a3, wd3, busy
    );

    modport slave (
        input  req, req_addr, req_data, stall,
        output gnt, we3, a3, wd3, busy
    );
endinterface

// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter for the single register-file write port.
// Grants are combinational; the winning write is registered onto we3/a3/wd3, and r0 writes are dropped.
module regfile_wr_arb #(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    regfile_wr_arb_if.slave  bus
);
    localparam int unsigned PW = $clog2(NREQ);

    logic [PW-1:0]   ptr_q, ptr_d;
    logic            we3_q, we3_d;
    logic [AW-1:0]   a3_q, a3_d;
    logic [DW-1:0]   wd3_q, wd3_d;

    logic [NREQ-1:0] gnt_c;
    logic            grant_vld;
    logic [PW-1:0]   win;
    logic [PW-1:0]   cand;
    int unsigned     idx;
    logic [AW-1:0]   win_addr;
    logic [DW-1:0]   win_data;

    // Scan from ptr upward with wrap; the first requester found wins.
    always_comb begin
        gnt_c     = '0;
        grant_vld = 1'b0;
        win       = '0;
        cand      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = PW'(idx);
            if (!grant_vld && !bus.stall && bus.req[cand]) begin
                grant_vld = 1'b1;
                win       = cand;
            end
        end
        // No grant may be issued while reset is asserted.
        if (!rst_n) begin
            grant_vld = 1'b0;
        end
        if (grant_vld) begin
            gnt_c[win] = 1'b1;
        end
    end

    always_comb begin
        win_addr = bus.req_addr[32'(win) * AW +: AW];
        win_data = bus.req_data[32'(win) * DW +: DW];
        ptr_d    = ptr_q;
        we3_d    = 1'b0;
        a3_d     = a3_q;
        wd3_d    = wd3_q;
        if (grant_vld) begin
            ptr_d = (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            a3_d  = win_addr;
            wd3_d = win_data;
            // Writes to r0 complete the handshake but never reach the register file.
            we3_d = |win_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
            we3_q <= 1'b0;
            a3_q  <= '0;
            wd3_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            we3_q <= we3_d;
            a3_q  <= a3_d;
            wd3_q <= wd3_d;
        end
    end

    assign bus.gnt  = gnt_c;
    assign bus.we3  = we3_q;
    assign bus.a3   = a3_q;
    assign bus.wd3  = wd3_q;
    assign bus.busy = (|bus.req) | we3_q;
endmodule
